// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory arbiter and its byte-lane helper
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  localparam logic P_FETCH = 1'b0;
  localparam logic P_DATA  = 1'b1;
endpackage

// File: rtl/mem_lane.sv
// mem_lane: store lane steering, load extraction/extension and misalignment detect
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  we_mask,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b        = rdata[{off, 3'b000} +: 8];
    h        = off[1] ? rdata[31:16] : rdata[15:0];
    misalign = size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? off[0] : |off;
    we_mask  = size == SZ_BYTE ? BE_B << off : size == SZ_HALF ? BE_H << off : BE_W;
    wdata_o  = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata_o  = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
               size == SZ_HALF ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter over a single-port RAM with byte-lane control
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);
  state_t state_q, state_d;
  logic last_q, last_d, port_q, port_d, we_q, we_d, err_q, err_d, uns_q, uns_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0] ram_we_q, ram_we_d;
  logic [31:0] ram_wdata_q, ram_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d, busy_q, busy_d;
  logic idle, i_elig, d_elig, gnt;
  logic [3:0] lane_we;
  logic [31:0] lane_wdata, lane_rdata;
  logic lane_mis;
  logic unused;
  assign unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2]};
  assign idle   = state_q == S_IDLE;
  assign i_elig = i_req & ~i_ack_q;
  assign d_elig = d_req & ~d_ack_q;
  assign gnt    = d_elig & (~i_elig | last_q == P_FETCH);
  // Lane unit sees live request fields while idle and the latched ones afterwards
  mem_lane u_lane (
    .size     (idle ? d_size : size_q),
    .off      (idle ? d_addr[1:0] : off_q),
    .uns      (idle ? d_unsigned : uns_q),
    .wdata    (d_wdata),
    .rdata    (ram_rdata),
    .we_mask  (lane_we),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata),
    .misalign (lane_mis)
  );
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    we_d        = we_q;
    err_d       = err_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = busy_q;
    ram_we_d    = '0;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    if (idle && (i_elig || d_elig)) begin
      state_d     = S_ACCESS;
      busy_d      = 1'b1;
      port_d      = gnt;
      last_d      = gnt;
      we_d        = gnt & d_we;
      err_d       = gnt & lane_mis;
      size_d      = d_size;
      off_d       = d_addr[1:0];
      uns_d       = d_unsigned;
      ram_addr_d  = gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
      ram_we_d    = (gnt && d_we && !lane_mis) ? lane_we : 4'b0000;
      ram_wdata_d = gnt ? lane_wdata : '0;
    end else if (state_q == S_ACCESS) begin
      state_d = S_RESP;
    end else if (state_q == S_RESP) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      i_ack_d   = port_q == P_FETCH;
      d_ack_d   = port_q == P_DATA;
      d_err_d   = port_q == P_DATA && err_q;
      i_rdata_d = port_q == P_FETCH ? ram_rdata : i_rdata_q;
      d_rdata_d = port_q == P_DATA ? ((err_q || we_q) ? '0 : lane_rdata) : d_rdata_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= P_FETCH;
      port_q      <= P_FETCH;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
      ram_addr_q  <= '0;
      ram_we_q    <= '0;
      ram_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      we_q        <= we_d;
      err_q       <= err_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      busy_q      <= busy_d;
    end
  end
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0] d_size = 2'b00;
  logic i_ack, d_ack, d_err, busy;
  logic [31:0] i_rdata, d_rdata, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [7:0] ram_addr;
  logic [3:0] ram_we;
  bit [31:0] mem [256];
  bit [31:0] ref_mem [256];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic misal(input logic [1:0] sz, input int off);
    return (off % nbytes(sz)) != 0;
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz, input logic un, input int off);
    int n;
    logic [31:0] v, m;
    n = nbytes(sz);
    v = w >> (8 * off);
    m = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v = v & m;
    if (!un && n < 4 && ((v >> (8 * n - 1)) & 32'h1) != 0) v = v | ~m;
    return v;
  endfunction
  task automatic run_d(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [3:0] we1, output logic [7:0] ra1,
                       output logic [31:0] wd1, output logic [31:0] rd, output logic er, output logic stray);
    d_we = we; d_size = sz; d_unsigned = un; d_addr = a; d_wdata = wd; d_req = 1'b1;
    lat = -1; we1 = '0; ra1 = '0; wd1 = '0; rd = '0; er = 1'b0; stray = 1'b0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin we1 = ram_we; ra1 = ram_addr; wd1 = ram_wdata; end
      else if (ram_we != 4'b0) stray = 1'b1;
      if (d_ack) begin lat = k; rd = d_rdata; er = d_err; end
    end
    d_req = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic run_i(input logic [31:0] a, output int lat, output logic [7:0] ra1,
                       output logic [31:0] rd, output logic wr);
    i_addr = a; i_req = 1'b1;
    lat = -1; ra1 = '0; rd = '0; wr = 1'b0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) ra1 = ram_addr;
      if (ram_we != 4'b0) wr = 1'b1;
      if (i_ack) begin lat = k; rd = i_rdata; end
    end
    i_req = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({i_ack, d_ack, d_err, busy} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {i_ack, d_ack, d_err, busy}); end
    checks++; if (ram_we !== 4'b0 || ram_addr !== 8'h0 || ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram got we=%b addr=%h wdata=%h exp all 0", ram_we, ram_addr, ram_wdata); end
    checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got i=%h d=%h exp 0", i_rdata, d_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask
  task automatic test_fetch;
    int lat; logic [3:0] we1; logic [7:0] ra; logic [31:0] wd, rd; logic er, st, wr;
    run_d(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, lat, we1, ra, wd, rd, er, st);
    checks++; if (we1 !== 4'b1111 || wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL preload_word got we=%b wdata=%h exp 1111/deadbeef", we1, wd); end
    run_i(32'h0C, lat, ra, rd, wr);
    checks++; if (lat !== 3) begin failures++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", rd); end
    checks++; if (ra !== 8'd3) begin failures++; $display("FAIL fetch_addr got=%0d exp=3", ra); end
    checks++; if (wr !== 1'b0) begin failures++; $display("FAIL fetch_we got=%b exp=0", wr); end
  endtask
  task automatic test_byte_store;
    int lat; logic [3:0] we1; logic [7:0] ra; logic [31:0] wd, rd; logic er, st;
    run_d(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, lat, we1, ra, wd, rd, er, st);
    run_d(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5, lat, we1, ra, wd, rd, er, st);
    checks++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL bstore_ack got lat=%0d err=%b rdata=%h exp 3/0/0", lat, er, rd); end
    checks++; if (ra !== 8'd4 || we1 !== 4'b0010) begin failures++; $display("FAIL bstore_lane got addr=%0d we=%b exp 4/0010", ra, we1); end
    checks++; if (wd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bstore_wdata got=%h exp=a5a5a5a5", wd); end
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL bstore_we_drop got=%b exp=0", st); end
    run_d(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (rd !== 32'h1122_A544) begin failures++; $display("FAIL bstore_readback got=%h exp=1122a544", rd); end
  endtask
  task automatic test_extend;
    int lat; logic [3:0] we1; logic [7:0] ra; logic [31:0] wd, rd; logic er, st;
    run_d(1'b1, 2'b10, 1'b0, 32'h10, 32'h00F0_8000, lat, we1, ra, wd, rd, er, st);
    run_d(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (rd !== 32'hFFFF_8000 || we1 !== 4'b0) begin failures++; $display("FAIL half_signed got=%h we=%b exp=ffff8000/0000", rd, we1); end
    run_d(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (rd !== 32'h0000_8000) begin failures++; $display("FAIL half_unsigned got=%h exp=00008000", rd); end
    run_d(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (rd !== 32'hFFFF_FFF0) begin failures++; $display("FAIL byte_signed got=%h exp=fffffff0", rd); end
  endtask
  task automatic test_misalign;
    int lat; logic [3:0] we1; logic [7:0] ra; logic [31:0] wd, rd; logic er, st;
    run_d(1'b1, 2'b10, 1'b0, 32'h04, 32'h5566_7788, lat, we1, ra, wd, rd, er, st);
    run_d(1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFF_FFFF, lat, we1, ra, wd, rd, er, st);
    checks++; if (lat !== 3 || er !== 1'b1 || rd !== 32'h0 || we1 !== 4'b0) begin failures++; $display("FAIL mis_store got lat=%0d err=%b rdata=%h we=%b exp 3/1/0/0000", lat, er, rd, we1); end
    run_d(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (lat !== 3 || er !== 1'b1 || rd !== 32'h0 || we1 !== 4'b0) begin failures++; $display("FAIL mis_load got lat=%0d err=%b rdata=%h we=%b exp 3/1/0/0000", lat, er, rd, we1); end
    run_d(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (rd !== 32'h5566_7788 || er !== 1'b0) begin failures++; $display("FAIL mis_unchanged got=%h err=%b exp=55667788/0", rd, er); end
  endtask
  task automatic test_contention;
    int n, port [8], cyc [8]; logic [31:0] dat [8]; logic dual;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    n = 0; dual = 1'b0;
    d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h0C; i_addr = 32'h10;
    d_req = 1'b1; i_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (d_ack && i_ack) dual = 1'b1;
      if ((d_ack || i_ack) && n < 8) begin port[n] = d_ack ? 1 : 0; cyc[n] = c; dat[n] = d_ack ? d_rdata : i_rdata; n++; end
      if (c == 12) begin d_req = 1'b0; i_req = 1'b0; end
    end
    checks++; if (n !== 4 || dual !== 1'b0) begin failures++; $display("FAIL rr_count got=%0d dual=%b exp=4/0", n, dual); end
    for (int i = 0; i < n; i++) begin
      checks++; if (port[i] !== ((i % 2 == 0) ? 1 : 0) || cyc[i] !== 3 * (i + 1)) begin failures++; $display("FAIL rr_order idx=%0d got port=%0d cyc=%0d exp port=%0d cyc=%0d", i, port[i], cyc[i], (i % 2 == 0) ? 1 : 0, 3 * (i + 1)); end
      checks++; if (dat[i] !== ((i % 2 == 0) ? 32'hDEAD_BEEF : 32'h00F0_8000)) begin failures++; $display("FAIL rr_data idx=%0d got=%h", i, dat[i]); end
    end
  endtask
  task automatic test_reset_midop;
    int lat, acks; logic [3:0] we1; logic [7:0] ra; logic [31:0] wd, rd; logic er, st;
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0C; d_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || ram_addr !== 8'd3) begin failures++; $display("FAIL midop_access got busy=%b addr=%0d exp 1/3", busy, ram_addr); end
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({i_ack, d_ack, d_err, busy, ram_we} !== 8'h0 || ram_addr !== 8'h0 || ram_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL midop_reset got ack=%b%b busy=%b we=%b addr=%h rd=%h", i_ack, d_ack, busy, ram_we, ram_addr, d_rdata); end
    acks = 0;
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; if (d_ack || i_ack) acks++; end
    checks++; if (acks !== 0) begin failures++; $display("FAIL midop_noack got=%0d exp=0", acks); end
    run_d(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, we1, ra, wd, rd, er, st);
    checks++; if (lat !== 3 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL midop_fresh got lat=%0d rdata=%h exp 3/deadbeef", lat, rd); end
  endtask
  task automatic test_random;
    int lat, w, off, n; logic [3:0] we1, em; logic [7:0] ra; logic [31:0] wd, rd, a, wv, ew, ed, bm;
    logic er, st, wr, we, un, m; logic [1:0] sz;
    for (int t = 0; t < 60; t++) begin
      w = 16 + $urandom_range(0, 15); off = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_FC00) | (w << 2) | off;
      if ($urandom_range(0, 3) == 0) begin
        run_i(a, lat, ra, rd, wr);
        checks++; if (lat !== 3 || rd !== ref_mem[w] || wr !== 1'b0 || ra !== w[7:0]) begin failures++; $display("FAIL rnd_fetch t=%0d got lat=%0d rd=%h we=%b addr=%0d exp 3/%h/0/%0d", t, lat, rd, wr, ra, ref_mem[w], w); end
      end else begin
        sz = 2'($urandom_range(0, 3)); we = 1'($urandom); un = 1'($urandom); wv = $urandom;
        n = nbytes(sz); m = misal(sz, off); em = '0; ew = '0;
        for (int i = 0; i < n; i++) if (!m && we) begin em[off+i] = 1'b1; ew[8*(off+i) +: 8] = wv[8*i +: 8]; end
        ed = (m || we) ? 32'h0 : model_load(ref_mem[w], sz, un, off);
        run_d(we, sz, un, a, wv, lat, we1, ra, wd, rd, er, st);
        bm = {{8{em[3]}}, {8{em[2]}}, {8{em[1]}}, {8{em[0]}}};
        checks++; if (lat !== 3 || er !== m || rd !== ed || st !== 1'b0) begin failures++; $display("FAIL rnd_resp t=%0d got lat=%0d err=%b rd=%h exp 3/%b/%h", t, lat, er, rd, m, ed); end
        checks++; if (we1 !== em || ra !== w[7:0] || (wd & bm) !== ew) begin failures++; $display("FAIL rnd_ram t=%0d got we=%b addr=%0d wd=%h exp %b/%0d/%h", t, we1, ra, wd & bm, em, w, ew); end
        if (we && !m) for (int i = 0; i < n; i++) ref_mem[w][8*(off+i) +: 8] = wv[8*i +: 8];
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_fetch;
    test_byte_store;
    test_extend;
    test_misalign;
    test_contention;
    test_reset_midop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
